// File: rtl/seq_counter_pkg.sv
// Shared constants and reset-table helper for the programmable sequence counter.
package seq_counter_pkg;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_DEPTH = 8;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Default table contents: entry i holds i modulo 2^w.
  function automatic int tbl_init(input int i, input int w);
    return i % (1 << w);
  endfunction

endpackage

// File: rtl/seq_table.sv
// DEPTH x WIDTH sequence table: one write port, one combinational write-through read port.
module seq_table
  import seq_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  // Out-of-range write addresses never match an entry, so they are dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst)
        mem[i] <= WIDTH'(tbl_init(i, WIDTH));
      else if (wr_en && int'(wr_addr) == i)
        mem[i] <= wr_data;
    end
  end

  // Bypass so a same-cycle write to the read address is visible immediately.
  always_comb begin
    rd_data = mem[rd_addr];
    if (wr_en && wr_addr == rd_addr) rd_data = wr_data;
  end

endmodule

// File: rtl/seq_counter.sv
// Programmable-sequence counter: walks a writable table with runtime length,
// direction, index load and a wrap pulse aligned to the wrapped output value.
module seq_counter
  import seq_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int IW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir_up,
  input  logic             load,
  input  logic [IW-1:0]    load_idx,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             len_we,
  input  logic [LW-1:0]    len_data,
  output logic [WIDTH-1:0] q,
  output logic [IW-1:0]    idx,
  output logic             wrap
);

  logic [LW-1:0]    len, len_n;
  logic [IW-1:0]    idx_n;
  logic             wrap_n;
  logic [WIDTH-1:0] rd_data;

  seq_table #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tbl (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_n),
    .rd_data (rd_data)
  );

  always_comb begin
    len_n = len;
    if (len_we && len_data != '0 && int'(len_data) <= DEPTH) len_n = len_data;

    idx_n  = idx;
    wrap_n = 1'b0;
    if (load) begin
      idx_n = (int'(load_idx) < int'(len_n)) ? load_idx : '0;
    end else if (int'(idx) >= int'(len_n)) begin
      // Length shrank below the current position: restart quietly.
      idx_n = '0;
    end else if (en) begin
      if (dir_up == DIR_UP) begin
        if (int'(idx) == int'(len_n) - 1) begin
          idx_n  = '0;
          wrap_n = 1'b1;
        end else begin
          idx_n = idx + 1'b1;
        end
      end else begin
        if (idx == '0) begin
          idx_n  = IW'(int'(len_n) - 1);
          wrap_n = 1'b1;
        end else begin
          idx_n = idx - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len  <= LW'(DEPTH);
      idx  <= '0;
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      len  <= len_n;
      idx  <= idx_n;
      q    <= rd_data;
      wrap <= wrap_n;
    end
  end

endmodule

// File: tb/tb_seq_counter.sv
// Randomized and directed bench for seq_counter against a table/arithmetic reference model.
module tb_seq_counter;

  localparam int WIDTH = 3;
  localparam int DEPTH = 8;
  localparam int IW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst, en, dir_up, load, wr_en, len_we;
  logic [IW-1:0]    load_idx, wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [LW-1:0]    len_data;
  logic [WIDTH-1:0] q;
  logic [IW-1:0]    idx;
  logic             wrap;

  int n_vec = 0;
  int n_err = 0;

  int m_tbl [DEPTH];
  int m_len, m_idx, m_q, m_wrap;

  seq_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .dir_up(dir_up), .load(load),
    .load_idx(load_idx), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len_we(len_we), .len_data(len_data), .q(q), .idx(idx), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: sequence position is arithmetic modulo the active length.
  task automatic model_step();
    int nl;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_tbl[i] = i % (1 << WIDTH);
      m_len = DEPTH; m_idx = 0; m_wrap = 0; m_q = 0;
      return;
    end
    if (wr_en && int'(wr_addr) < DEPTH) m_tbl[wr_addr] = wr_data;
    nl = (len_we && len_data >= 1 && int'(len_data) <= DEPTH) ? int'(len_data) : m_len;
    m_wrap = 0;
    if (load)              m_idx = (int'(load_idx) < nl) ? int'(load_idx) : 0;
    else if (m_idx >= nl)  m_idx = 0;
    else if (en) begin
      if (dir_up) begin
        m_wrap = (m_idx + 1 == nl);
        m_idx  = (m_idx + 1) % nl;
      end else begin
        m_wrap = (m_idx == 0);
        m_idx  = (m_idx + nl - 1) % nl;
      end
    end
    m_len = nl;
    m_q   = m_tbl[m_idx];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("q", q, m_q);
    chk("idx", idx, m_idx);
    chk("wrap", wrap, m_wrap);
  endtask

  task automatic idle_in();
    rst = 0; en = 0; dir_up = 1; load = 0; load_idx = '0;
    wr_en = 0; wr_addr = '0; wr_data = '0; len_we = 0; len_data = '0;
  endtask

  int exp_up  [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
  int leg_tbl [5] = '{0, 2, 3, 5, 7};
  int exp_leg [7] = '{0, 2, 3, 5, 7, 0, 2};
  int exp_dn  [6] = '{7, 5, 3, 2, 0, 7};

  initial begin
    idle_in();
    rst = 1;
    tick(); tick();
    chk("rst_q", q, 0); chk("rst_idx", idx, 0); chk("rst_wrap", wrap, 0);
    rst = 0;

    // Default table counts 0..7.
    en = 1; dir_up = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("up_q", q, exp_up[i]);
      chk("up_wrap", wrap, (i == 7) ? 1 : 0);
    end
    idle_in();

    // Legacy 0,2,3,5,7 sequence.
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; wr_addr = IW'(i); wr_data = WIDTH'(leg_tbl[i]);
      tick();
    end
    idle_in();
    len_we = 1; len_data = LW'(5); load = 1; load_idx = '0;
    tick();
    chk("leg_q", q, exp_leg[0]);
    idle_in();
    en = 1; dir_up = 1;
    for (int i = 1; i < 7; i++) begin
      tick();
      chk("leg_q", q, exp_leg[i]);
      chk("leg_wrap", wrap, (i == 5) ? 1 : 0);
    end
    idle_in();
    load = 1; load_idx = '0; tick();
    idle_in();
    en = 1; dir_up = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("dn_q", q, exp_dn[i]);
      chk("dn_wrap", wrap, (i == 0 || i == 5) ? 1 : 0);
    end
    idle_in();

    // Shrinking length below the current index restarts at 0 with no wrap.
    len_we = 1; len_data = LW'(8); load = 1; load_idx = IW'(6); tick();
    chk("ld6_idx", idx, 6);
    idle_in();
    len_we = 1; len_data = LW'(4); tick();
    chk("shr_idx", idx, 0); chk("shr_q", q, 0); chk("shr_wrap", wrap, 0);
    len_data = LW'(0); tick();
    len_data = LW'(9); tick();
    idle_in();
    en = 1; dir_up = 1;
    tick(); tick(); tick(); chk("len4_idx", idx, 3);
    tick(); chk("len4_wrap", wrap, 1); chk("len4_idx0", idx, 0);
    idle_in();

    // Write-through on a step and on an idle cycle.
    load = 1; load_idx = IW'(2); tick();
    idle_in();
    en = 1; wr_en = 1; wr_addr = IW'(3); wr_data = WIDTH'(6); tick();
    chk("wt_step_q", q, 6);
    idle_in();
    wr_en = 1; wr_addr = IW'(3); wr_data = WIDTH'(1); tick();
    chk("wt_idle_q", q, 1);
    idle_in();

    // Load beyond length falls back to 0; reset beats everything.
    load = 1; load_idx = IW'(5); tick();
    chk("ld_oob_idx", idx, 0);
    idle_in();
    en = 1; tick();
    rst = 1; en = 1; load = 1; load_idx = IW'(3); wr_en = 1; wr_addr = IW'(1); wr_data = WIDTH'(5);
    len_we = 1; len_data = LW'(2);
    tick();
    chk("rst2_q", q, 0); chk("rst2_idx", idx, 0); chk("rst2_wrap", wrap, 0);
    idle_in();
    en = 1; for (int i = 1; i < 8; i++) begin tick(); chk("deftbl_q", q, i); end
    idle_in();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      en       = $urandom_range(0, 3) != 0;
      dir_up   = $urandom_range(0, 1) != 0;
      load     = ($urandom_range(0, 9) == 0);
      load_idx = IW'($urandom);
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_addr  = IW'($urandom);
      wr_data  = WIDTH'($urandom);
      len_we   = ($urandom_range(0, 7) == 0);
      len_data = LW'($urandom_range(0, (1 << LW) - 1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
